// File: rtl/bamse_io_pkg.sv
// rtl/bamse_io_pkg.sv - shared constants and FSM state type for the bamse I/O port block
package bamse_io_pkg;

    localparam int BYTE_W = 8;

    // Control register offsets relative to CTRL_BASE
    localparam logic [7:0] IOC_EN_OFS    = 8'd0;
    localparam logic [7:0] IOC_MODE_OFS  = 8'd1;
    localparam logic [7:0] IOC_FLAGS_OFS = 8'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } ioc_state_t;

endpackage

// File: rtl/bamse_sync_edge.sv
// rtl/bamse_sync_edge.sv - 2-flop pin synchroniser with change/rising-edge event detect
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   din        asynchronous pin byte
//   mode       0: event on any bit change, 1: event on any rising bit
//   sync       synchronised pin value
//   evt        mode-qualified event, valid while sync differs from the previous sample
module bamse_sync_edge
    import bamse_io_pkg::*;
#(
    parameter int WIDTH = BYTE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             mode,
    output logic [WIDTH-1:0] sync,
    output logic             evt
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev;
    logic             change;
    logic             rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= '0;
            sync_q <= '0;
            prev   <= '0;
        end else begin
            meta   <= din;
            sync_q <= meta;
            prev   <= sync_q;
        end
    end

    assign change = (sync_q != prev);
    assign rise   = |(sync_q & ~prev);
    assign evt    = mode ? rise : change;
    assign sync   = sync_q;

endmodule

// File: rtl/bamse_io_ioc.sv
// rtl/bamse_io_ioc.sv - PacoBlaze3 I/O port block with interrupt-on-change
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   port_in     NUM_IN pin bytes (asynchronous), port i at [8i+7:8i]
//   port_outs   NUM_OUT output bytes, port j at [8j+7:8j]
//   port_id     port address from the CPU
//   wen, ren    CPU write/read strobes (reads have no side effects)
//   pb_out      CPU write data
//   pb_in       registered read data (1-cycle latency from port_id)
//   interrupt   registered interrupt request
//   int_ack     CPU interrupt acknowledge
module bamse_io_ioc
    import bamse_io_pkg::*;
#(
    parameter int         NUM_IN    = 2,
    parameter int         NUM_OUT   = 1,
    parameter logic [7:0] IN_BASE   = 8'h00,
    parameter logic [7:0] OUT_BASE  = 8'h10,
    parameter logic [7:0] CTRL_BASE = 8'h20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_IN-1:0]    port_in,
    output logic [8*NUM_OUT-1:0]   port_outs,
    input  logic [7:0]             port_id,
    input  logic                   wen,
    input  logic                   ren,
    input  logic [7:0]             pb_out,
    output logic [7:0]             pb_in,
    output logic                   interrupt,
    input  logic                   int_ack
);

    logic [NUM_IN-1:0][7:0]  sync_v;
    logic [NUM_IN-1:0]       evt;
    logic [NUM_OUT-1:0][7:0] outs;
    logic [NUM_IN-1:0]       ioc_en;
    logic [NUM_IN-1:0]       ioc_mode;
    logic [NUM_IN-1:0]       ioc_flags;
    logic [NUM_IN-1:0]       flag_clr;
    logic [7:0]              in_ofs;
    logic [7:0]              out_ofs;
    logic [7:0]              ctrl_ofs;
    logic [7:0]              rd_data;
    logic                    pend;
    ioc_state_t              state_q;
    ioc_state_t              state_d;
    logic                    unused_ren;

    // Read strobe carries no side effects; the read mux runs every cycle.
    assign unused_ren = ren;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
        bamse_sync_edge #(.WIDTH(BYTE_W)) u_sync (
            .clk  (clk),
            .rst  (rst),
            .din  (port_in[8*gi +: 8]),
            .mode (ioc_mode[gi]),
            .sync (sync_v[gi]),
            .evt  (evt[gi])
        );
    end

    // Offsets wrap modulo 256, so an id below a base yields a large offset
    // that matches no index.
    assign in_ofs   = port_id - IN_BASE;
    assign out_ofs  = port_id - OUT_BASE;
    assign ctrl_ofs = port_id - CTRL_BASE;

    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NUM_IN; i++) begin
            if (in_ofs == 8'(i)) rd_data = sync_v[i];
        end
        for (int j = 0; j < NUM_OUT; j++) begin
            if (out_ofs == 8'(j)) rd_data = outs[j];
        end
        if (ctrl_ofs == IOC_EN_OFS)    rd_data = 8'(ioc_en);
        if (ctrl_ofs == IOC_MODE_OFS)  rd_data = 8'(ioc_mode);
        if (ctrl_ofs == IOC_FLAGS_OFS) rd_data = 8'(ioc_flags);
    end

    assign flag_clr = (wen && ctrl_ofs == IOC_FLAGS_OFS) ? pb_out[NUM_IN-1:0] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            outs      <= '0;
            ioc_en    <= '0;
            ioc_mode  <= '0;
            ioc_flags <= '0;
            pb_in     <= 8'h00;
        end else begin
            pb_in <= rd_data;
            if (wen) begin
                for (int j = 0; j < NUM_OUT; j++) begin
                    if (out_ofs == 8'(j)) outs[j] <= pb_out;
                end
                if (ctrl_ofs == IOC_EN_OFS)   ioc_en   <= pb_out[NUM_IN-1:0];
                if (ctrl_ofs == IOC_MODE_OFS) ioc_mode <= pb_out[NUM_IN-1:0];
            end
            // OR-ing events after the clear lets a coincident event win.
            ioc_flags <= (ioc_flags & ~flag_clr) | evt;
        end
    end

    assign port_outs = outs;
    assign pend      = |(ioc_flags & ioc_en);

    // SERVICE holds interrupt low until the ISR has cleared the enabled
    // flags, so the same flags cannot re-trigger after the acknowledge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (pend) state_d = ST_REQ;
            ST_REQ: begin
                if (!pend)        state_d = ST_IDLE;
                else if (int_ack) state_d = ST_SERVICE;
            end
            ST_SERVICE: if (!pend) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            interrupt <= 1'b0;
        end else begin
            state_q   <= state_d;
            interrupt <= (state_d == ST_REQ);
        end
    end

endmodule

// File: tb/tb_bamse_io_ioc.sv
// tb/tb_bamse_io_ioc.sv - self-checking bench for bamse_io_ioc (NUM_IN=2, NUM_OUT=1)
module tb_bamse_io_ioc;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] port_in;
    logic [7:0]  port_outs;
    logic [7:0]  port_id;
    logic        wen;
    logic        ren;
    logic [7:0]  pb_out;
    logic [7:0]  pb_in;
    logic        interrupt;
    logic        int_ack;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bamse_io_ioc dut (
        .clk       (clk),
        .rst       (rst),
        .port_in   (port_in),
        .port_outs (port_outs),
        .port_id   (port_id),
        .wen       (wen),
        .ren       (ren),
        .pb_out    (pb_out),
        .pb_in     (pb_in),
        .interrupt (interrupt),
        .int_ack   (int_ack)
    );

    typedef struct {
        bit         wr;
        logic [7:0] id;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[14];

    // Reference model state: pin samples taken at the last three edges,
    // register contents, and the interrupt phase (0 quiet, 1 requesting, 2 acked).
    logic [15:0] hist[3];
    logic [7:0]  m_outs;
    logic [1:0]  m_en, m_mode, m_flags;
    logic [7:0]  m_pbin;
    int          m_phase;
    logic        m_irq;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] id, input logic [7:0] d);
        wen = 1'b1; port_id = id; pb_out = d;
        tick();
        wen = 1'b0;
    endtask

    task automatic rd(input logic [7:0] id, output logic [7:0] v);
        port_id = id;
        ren = 1'b1;
        tick();
        ren = 1'b0;
        v = pb_in;
    endtask

    // Advance the model across the coming clock edge using the inputs now driven.
    task automatic model_step();
        logic [15:0] s, p;
        logic [1:0]  ev;
        logic [1:0]  clr;
        logic [7:0]  rv;
        logic        pend;
        int          nph;
        if (rst) begin
            for (int k = 0; k < 3; k++) hist[k] = 16'h0;
            m_outs = 0; m_en = 0; m_mode = 0; m_flags = 0;
            m_pbin = 0; m_phase = 0; m_irq = 0;
        end else begin
            s = hist[1];
            p = hist[2];
            for (int i = 0; i < 2; i++) begin
                if (m_mode[i]) ev[i] = ((s[8*i +: 8] & ~p[8*i +: 8]) != 8'h00);
                else           ev[i] = (s[8*i +: 8] != p[8*i +: 8]);
            end
            case (port_id)
                8'h00:   rv = s[7:0];
                8'h01:   rv = s[15:8];
                8'h10:   rv = m_outs;
                8'h20:   rv = {6'b0, m_en};
                8'h21:   rv = {6'b0, m_mode};
                8'h22:   rv = {6'b0, m_flags};
                default: rv = 8'h00;
            endcase
            pend = ((m_flags & m_en) != 2'b00);
            if (m_phase == 0)      nph = pend ? 1 : 0;
            else if (m_phase == 1) nph = !pend ? 0 : (int_ack ? 2 : 1);
            else                   nph = pend ? 2 : 0;
            clr = 2'b00;
            if (wen) begin
                case (port_id)
                    8'h10:   m_outs = pb_out;
                    8'h20:   m_en = pb_out[1:0];
                    8'h21:   m_mode = pb_out[1:0];
                    8'h22:   clr = pb_out[1:0];
                    default: ;
                endcase
            end
            m_flags = (m_flags & ~clr) | ev;
            m_pbin  = rv;
            m_phase = nph;
            m_irq   = (nph == 1);
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = port_in;
        end
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] ids[9];

        tbl[0]  = '{1'b1, 8'h10, 8'hA5, 8'hA5};
        tbl[1]  = '{1'b0, 8'h27, 8'h00, 8'h00};
        tbl[2]  = '{1'b0, 8'h11, 8'h00, 8'h00};
        tbl[3]  = '{1'b0, 8'h02, 8'h00, 8'h00};
        tbl[4]  = '{1'b0, 8'h30, 8'h00, 8'h00};
        tbl[5]  = '{1'b1, 8'h20, 8'hFF, 8'h03};
        tbl[6]  = '{1'b1, 8'h21, 8'hFE, 8'h02};
        tbl[7]  = '{1'b1, 8'h23, 8'h77, 8'h00};
        tbl[8]  = '{1'b1, 8'h20, 8'h00, 8'h00};
        tbl[9]  = '{1'b1, 8'h21, 8'h00, 8'h00};
        tbl[10] = '{1'b1, 8'h00, 8'h55, 8'h00};
        tbl[11] = '{1'b1, 8'h11, 8'h5A, 8'h00};
        tbl[12] = '{1'b0, 8'h10, 8'h00, 8'hA5};
        tbl[13] = '{1'b0, 8'h22, 8'h00, 8'h00};

        ids[0] = 8'h00; ids[1] = 8'h01; ids[2] = 8'h02; ids[3] = 8'h10; ids[4] = 8'h11;
        ids[5] = 8'h20; ids[6] = 8'h21; ids[7] = 8'h22; ids[8] = 8'h23;

        // Reset with pins high
        rst = 1'b1; wen = 1'b0; ren = 1'b0; int_ack = 1'b0;
        port_id = 8'h22; pb_out = 8'h00; port_in = 16'hFFFF;
        repeat (3) tick();
        check("rst_outs", port_outs, 8'h00);
        check("rst_irq", interrupt, 1'b0);
        check("rst_pbin", pb_in, 8'h00);
        rst = 1'b0;
        rd(8'h20, v); check("rst_en", v, 8'h00);
        rd(8'h21, v); check("rst_mode", v, 8'h00);
        rd(8'h22, v); check("rst_flags", v, 8'h00);
        port_in = 16'h0000;
        repeat (4) tick();
        wr(8'h22, 8'hFF);

        // Register map vectors
        for (int k = 0; k < 14; k++) begin
            if (tbl[k].wr) begin
                wr(tbl[k].id, tbl[k].data);
                if (tbl[k].id == 8'h10) check("outs_wr", port_outs, tbl[k].data);
            end
            rd(tbl[k].id, v);
            check($sformatf("tbl%0d_rd", k), v, tbl[k].exp);
        end

        // Input pin path through the synchroniser
        port_in = 16'h3C00;
        repeat (3) tick();
        rd(8'h01, v); check("pin_p1", v, 8'h3C);
        tick();
        wr(8'h22, 8'hFF);

        // Any-change interrupt on port 0
        wr(8'h20, 8'h01); wr(8'h21, 8'h00);
        port_in = 16'h3C10;
        repeat (3) tick();
        check("chg_irq_early", interrupt, 1'b0);
        tick();
        check("chg_irq", interrupt, 1'b1);
        rd(8'h22, v); check("chg_flags", v, 8'h01);
        repeat (2) tick();
        check("chg_irq_held", interrupt, 1'b1);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        check("chg_ack", interrupt, 1'b0);
        repeat (2) tick();
        check("chg_service", interrupt, 1'b0);
        wr(8'h22, 8'h01);
        repeat (3) tick();
        check("chg_no_retrig", interrupt, 1'b0);
        rd(8'h22, v); check("chg_cleared", v, 8'h00);

        // Rising-only interrupt on port 1
        port_in = 16'hF010;
        repeat (4) tick();
        wr(8'h22, 8'hFF);
        wr(8'h20, 8'h02); wr(8'h21, 8'h02);
        port_in = 16'h0010;
        repeat (5) tick();
        check("rise_fall_irq", interrupt, 1'b0);
        rd(8'h22, v); check("rise_fall_flags", v, 8'h00);
        port_in = 16'h0110;
        repeat (4) tick();
        check("rise_irq", interrupt, 1'b1);
        rd(8'h22, v); check("rise_flags", v, 8'h02);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        wr(8'h22, 8'h02);
        repeat (2) tick();
        check("rise_done", interrupt, 1'b0);

        // W1C coinciding with a new event on the same flag
        wr(8'h20, 8'h01); wr(8'h21, 8'h00);
        port_in = 16'h0120;
        repeat (4) tick();
        check("race_pre", interrupt, 1'b1);
        port_in = 16'h0130;
        tick(); tick();
        wen = 1'b1; port_id = 8'h22; pb_out = 8'h01;
        tick();
        wen = 1'b0;
        tick();
        check("race_irq", interrupt, 1'b1);
        rd(8'h22, v); check("race_flags", v, 8'h01);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        wr(8'h22, 8'h01);
        repeat (2) tick();
        check("race_done", interrupt, 1'b0);

        // Reset while requesting
        port_in = 16'h0140;
        repeat (4) tick();
        check("mrst_pre", interrupt, 1'b1);
        rst = 1'b1; tick();
        check("mrst_irq", interrupt, 1'b0);
        check("mrst_outs", port_outs, 8'h00);
        check("mrst_pbin", pb_in, 8'h00);
        rst = 1'b0;
        rd(8'h22, v); check("mrst_flags", v, 8'h00);
        check("mrst_irq_after", interrupt, 1'b0);

        // Randomised run against the reference model
        rst = 1'b1; model_step(); tick(); model_step(); tick();
        rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) port_in = port_in ^ (16'h1 << $urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) port_in = 16'($urandom);
            wen     = ($urandom_range(0, 3) == 0);
            port_id = ($urandom_range(0, 9) == 9) ? 8'($urandom) : ids[$urandom_range(0, 8)];
            pb_out  = 8'($urandom);
            int_ack = ($urandom_range(0, 4) == 0);
            rst     = ($urandom_range(0, 299) == 0);
            model_step();
            tick();
            check($sformatf("rnd%0d_pbin", n), pb_in, m_pbin);
            check($sformatf("rnd%0d_irq", n), interrupt, m_irq);
            check($sformatf("rnd%0d_outs", n), port_outs, m_outs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
